// File: rtl/trig_pkg.sv
// rtl/trig_pkg.sv - shared state encoding, trigerr bit indices and latency defaults for the trigger sequencer
package trig_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    WAIT_L1 = 4'b0010,
    WAIT_L2 = 4'b0100,
    HOLD    = 4'b1000
  } trig_state_t;

  localparam int TMR_W      = 12;
  localparam int CNT_W      = 12;
  localparam int TRIGERR_W  = 6;

  localparam int ERR_L1_IDLE  = 0;
  localparam int ERR_L1_EARLY = 1;
  localparam int ERR_L1_LATE  = 2;
  localparam int ERR_L2_PROTO = 3;
  localparam int ERR_L2_TMO   = 4;
  localparam int ERR_L0_BUSY  = 5;

  localparam int L1_MIN_DEF = 250;
  localparam int L1_MAX_DEF = 270;
  localparam int L2_TMO_DEF = 4000;

endpackage

// File: rtl/ttc_trig_timer.sv
// rtl/ttc_trig_timer.sv - saturating up-counter with synchronous clear
module ttc_trig_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt != {W{1'b1}}) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ttc_trig_seq.sv
// rtl/ttc_trig_seq.sv - L0/L1/L2 trigger sequencer with latency window, L2 timeout and sticky error flags
// Macro TTC_TRIG_SEQ_STAT_EN enables the l1/l2a/l2r event counters.
module ttc_trig_seq
  import trig_pkg::*;
#(
  parameter int L1_MIN = L1_MIN_DEF,
  parameter int L1_MAX = L1_MAX_DEF,
  parameter int L2_TMO = L2_TMO_DEF
) (
  input  logic                 gclk_40m,
  input  logic                 reset,
  input  logic                 ttc_l0,
  input  logic                 ttc_l1,
  input  logic                 ttc_l2a,
  input  logic                 ttc_l2r,
  input  logic                 ttc_feereset,
  input  logic                 rdo_busy,
  input  logic                 trigerr_clr,
  output logic                 fee_trig,
  output logic                 rdo_start,
  output logic                 rdo_abort,
  output logic                 trig_busy,
  output logic [TRIGERR_W-1:0] trigerr,
  output logic [CNT_W-1:0]     l1_cnt,
  output logic [CNT_W-1:0]     l2a_cnt,
  output logic [CNT_W-1:0]     l2r_cnt
);

  localparam logic [TMR_W-1:0] L1_MIN_T = TMR_W'(L1_MIN);
  localparam logic [TMR_W-1:0] L1_MAX_T = TMR_W'(L1_MAX);
  localparam logic [TMR_W-1:0] L2_TMO_T = TMR_W'(L2_TMO);

  trig_state_t          state, state_next;
  logic [TMR_W-1:0]     timer;
  logic                 tmr_clr;
  logic                 fee_trig_n, rdo_start_n, rdo_abort_n;
  logic [TRIGERR_W-1:0] err_set;
  logic                 inc_l1, inc_l2a, inc_l2r;

  ttc_trig_timer #(.W(TMR_W)) u_timer (
    .clk   (gclk_40m),
    .reset (reset),
    .clr   (tmr_clr),
    .cnt   (timer)
  );

  always_comb begin
    state_next  = state;
    tmr_clr     = 1'b0;
    fee_trig_n  = 1'b0;
    rdo_start_n = 1'b0;
    rdo_abort_n = 1'b0;
    err_set     = '0;
    inc_l1      = 1'b0;
    inc_l2a     = 1'b0;
    inc_l2r     = 1'b0;

    if (ttc_feereset) begin
      // FEE reset overrides every other input and leaves trigerr untouched
      state_next  = IDLE;
      tmr_clr     = 1'b1;
      rdo_abort_n = (state == WAIT_L2) || (state == HOLD);
    end else begin
      if (ttc_l1 && (state == IDLE))               err_set[ERR_L1_IDLE]  = 1'b1;
      if ((ttc_l2a || ttc_l2r) && (state != WAIT_L2)) err_set[ERR_L2_PROTO] = 1'b1;
      if (ttc_l0 && (state != IDLE))               err_set[ERR_L0_BUSY]  = 1'b1;

      case (state)
        IDLE: begin
          if (ttc_l0) state_next = WAIT_L1;
        end
        WAIT_L1: begin
          if (timer > L1_MAX_T) begin
            err_set[ERR_L1_LATE] = 1'b1;
            state_next           = IDLE;
          end else if (ttc_l1) begin
            if (timer < L1_MIN_T) begin
              err_set[ERR_L1_EARLY] = 1'b1;
              state_next            = IDLE;
            end else begin
              fee_trig_n = 1'b1;
              inc_l1     = 1'b1;
              state_next = WAIT_L2;
            end
          end
        end
        WAIT_L2: begin
          // a simultaneous accept+reject is resolved as a reject and flagged
          if (ttc_l2r) begin
            rdo_abort_n = 1'b1;
            inc_l2r     = 1'b1;
            state_next  = IDLE;
            if (ttc_l2a) err_set[ERR_L2_PROTO] = 1'b1;
          end else if (ttc_l2a) begin
            rdo_start_n = 1'b1;
            inc_l2a     = 1'b1;
            state_next  = HOLD;
          end else if (timer == L2_TMO_T) begin
            err_set[ERR_L2_TMO] = 1'b1;
            rdo_abort_n         = 1'b1;
            state_next          = IDLE;
          end
        end
        HOLD: begin
          if (!rdo_busy) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase

      if (state_next != state) tmr_clr = 1'b1;
    end
  end

  always_ff @(posedge gclk_40m) begin
    if (reset) begin
      state     <= IDLE;
      fee_trig  <= 1'b0;
      rdo_start <= 1'b0;
      rdo_abort <= 1'b0;
      trig_busy <= 1'b0;
      trigerr   <= '0;
    end else begin
      state     <= state_next;
      fee_trig  <= fee_trig_n;
      rdo_start <= rdo_start_n;
      rdo_abort <= rdo_abort_n;
      trig_busy <= (state_next != IDLE);
      // newly raised flags win over a clear in the same cycle
      trigerr   <= ((trigerr_clr && !ttc_feereset) ? '0 : trigerr) | err_set;
    end
  end

`ifdef TTC_TRIG_SEQ_STAT_EN
  always_ff @(posedge gclk_40m) begin
    if (reset || ttc_feereset) begin
      l1_cnt  <= '0;
      l2a_cnt <= '0;
      l2r_cnt <= '0;
    end else begin
      if (inc_l1)  l1_cnt  <= l1_cnt  + 1'b1;
      if (inc_l2a) l2a_cnt <= l2a_cnt + 1'b1;
      if (inc_l2r) l2r_cnt <= l2r_cnt + 1'b1;
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^{inc_l1, inc_l2a, inc_l2r};
  assign l1_cnt  = '0;
  assign l2a_cnt = '0;
  assign l2r_cnt = '0;
`endif

endmodule

// File: tb/tb_ttc_trig_seq.sv
// tb/tb_ttc_trig_seq.sv - directed self-checking bench for the trigger sequencer
module tb_ttc_trig_seq;

`ifdef TTC_TRIG_SEQ_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        gclk_40m = 1'b0;
  logic        reset = 1'b1;
  logic        ttc_l0 = 1'b0, ttc_l1 = 1'b0, ttc_l2a = 1'b0, ttc_l2r = 1'b0;
  logic        ttc_feereset = 1'b0, rdo_busy = 1'b0, trigerr_clr = 1'b0;
  logic        fee_trig, rdo_start, rdo_abort, trig_busy;
  logic [5:0]  trigerr;
  logic [11:0] l1_cnt, l2a_cnt, l2r_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  ttc_trig_seq dut (
    .gclk_40m     (gclk_40m),
    .reset        (reset),
    .ttc_l0       (ttc_l0),
    .ttc_l1       (ttc_l1),
    .ttc_l2a      (ttc_l2a),
    .ttc_l2r      (ttc_l2r),
    .ttc_feereset (ttc_feereset),
    .rdo_busy     (rdo_busy),
    .trigerr_clr  (trigerr_clr),
    .fee_trig     (fee_trig),
    .rdo_start    (rdo_start),
    .rdo_abort    (rdo_abort),
    .trig_busy    (trig_busy),
    .trigerr      (trigerr),
    .l1_cnt       (l1_cnt),
    .l2a_cnt      (l2a_cnt),
    .l2r_cnt      (l2r_cnt)
  );

  always #5 gclk_40m = ~gclk_40m;

  task automatic tick();
    @(posedge gclk_40m);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
    return STAT ? 32'(v) : 32'd0;
  endfunction

  task automatic pulse_l0();  ttc_l0 = 1'b1;  tick(); ttc_l0 = 1'b0;  endtask
  task automatic pulse_l1();  ttc_l1 = 1'b1;  tick(); ttc_l1 = 1'b0;  endtask
  task automatic pulse_l2a(); ttc_l2a = 1'b1; tick(); ttc_l2a = 1'b0; endtask
  task automatic pulse_l2r(); ttc_l2r = 1'b1; tick(); ttc_l2r = 1'b0; endtask
  task automatic pulse_clr(); trigerr_clr = 1'b1; tick(); trigerr_clr = 1'b0; endtask
  task automatic pulse_fee(); ttc_feereset = 1'b1; tick(); ttc_feereset = 1'b0; endtask

  initial begin
    // reset state
    idle(3);
    chk("rst_busy", trig_busy, 0);
    chk("rst_pulses", {fee_trig, rdo_start, rdo_abort}, 0);
    chk("rst_trigerr", trigerr, 0);
    chk("rst_cnts", {l1_cnt, l2a_cnt, l2r_cnt}, 0);
    reset = 1'b0;
    tick();

    // normal accept: L1 at timer 259, L2a at timer 999
    pulse_l0();
    chk("acc_busy_l1", trig_busy, 1);
    idle(259);
    pulse_l1();
    chk("acc_fee", fee_trig, 1);
    chk("acc_l1cnt", l1_cnt, cnt_exp(1));
    tick();
    chk("acc_fee_1cyc", {fee_trig, trig_busy}, 2'b01);
    idle(998);
    pulse_l2a();
    chk("acc_start", {rdo_start, rdo_abort, trig_busy}, 3'b101);
    chk("acc_l2acnt", l2a_cnt, cnt_exp(1));
    tick();
    chk("acc_hold_exit", {rdo_start, trig_busy}, 2'b00);
    chk("acc_trigerr", trigerr, 0);

    // L1 exactly at L1_MIN is accepted, then reject
    pulse_l0();
    idle(250);
    pulse_l1();
    chk("min_fee", fee_trig, 1);
    pulse_l2r();
    chk("rej_abort", {rdo_abort, rdo_start, trig_busy}, 3'b100);
    chk("rej_l2rcnt", l2r_cnt, cnt_exp(1));
    chk("rej_l1cnt", l1_cnt, cnt_exp(2));

    // L1 one cycle early
    pulse_l0();
    idle(249);
    pulse_l1();
    chk("early_fee", {fee_trig, trig_busy}, 2'b00);
    chk("early_err", trigerr, 6'b000010);
    pulse_clr();
    chk("clr_err", trigerr, 0);

    // late: still waiting at timer 270, times out at 271
    pulse_l0();
    idle(271);
    chk("late_wait", {trig_busy, trigerr}, {1'b1, 6'b000000});
    tick();
    chk("late_err", {trig_busy, trigerr}, {1'b0, 6'b000100});

    // L1 exactly at L1_MAX accepted, then L2 timeout at 4000
    pulse_l0();
    idle(270);
    pulse_l1();
    chk("max_fee", fee_trig, 1);
    chk("max_l1cnt", l1_cnt, cnt_exp(3));
    idle(4000);
    chk("tmo_wait", {trig_busy, rdo_abort}, 2'b10);
    tick();
    chk("tmo_abort", {trig_busy, rdo_abort}, 2'b01);
    chk("tmo_err", trigerr, 6'b010100);
    pulse_clr();

    // simultaneous L2a + L2r
    pulse_l0();
    idle(255);
    pulse_l1();
    ttc_l2a = 1'b1; ttc_l2r = 1'b1;
    tick();
    ttc_l2a = 1'b0; ttc_l2r = 1'b0;
    chk("both_pulses", {rdo_abort, rdo_start, trig_busy}, 3'b100);
    chk("both_l2rcnt", l2r_cnt, cnt_exp(2));
    chk("both_l2acnt", l2a_cnt, cnt_exp(1));
    chk("both_err", trigerr, 6'b001000);

    // L1 in IDLE
    pulse_l1();
    chk("l1idle_err", {trig_busy, fee_trig, trigerr}, {2'b00, 6'b001001});

    // clear and a new flag in the same cycle
    trigerr_clr = 1'b1; ttc_l1 = 1'b1;
    tick();
    trigerr_clr = 1'b0; ttc_l1 = 1'b0;
    chk("clr_vs_set", trigerr, 6'b000001);
    pulse_clr();

    // L0 during HOLD with readout busy
    pulse_l0();
    idle(260);
    pulse_l1();
    idle(10);
    rdo_busy = 1'b1;
    pulse_l2a();
    chk("hold_start", {rdo_start, trig_busy}, 2'b11);
    pulse_l0();
    chk("hold_l0_err", {trig_busy, trigerr}, {1'b1, 6'b100000});
    idle(5);
    chk("hold_kept", trig_busy, 1);
    rdo_busy = 1'b0;
    tick();
    chk("hold_exit", trig_busy, 0);

    // L2a outside WAIT_L2
    pulse_l2a();
    chk("l2a_idle", {rdo_start, trigerr}, {1'b0, 6'b101000});

    // FEE reset in WAIT_L2
    pulse_l0();
    idle(260);
    pulse_l1();
    chk("fee_pre_l1cnt", l1_cnt, cnt_exp(6));
    idle(3);
    pulse_fee();
    chk("fee_abort", {rdo_abort, trig_busy}, 2'b10);
    chk("fee_cnts", {l1_cnt, l2a_cnt, l2r_cnt}, 0);
    chk("fee_trigerr", trigerr, 6'b101000);
    pulse_fee();
    chk("fee_idle_noabort", rdo_abort, 0);

    // hard reset in WAIT_L2
    pulse_l0();
    idle(260);
    pulse_l1();
    chk("rst2_l1cnt", l1_cnt, cnt_exp(1));
    reset = 1'b1;
    tick();
    chk("rst2_state", {rdo_abort, trig_busy, fee_trig}, 0);
    chk("rst2_err_cnt", {trigerr, l1_cnt}, 0);
    reset = 1'b0;
    tick();
    chk("rst2_after", {rdo_abort, trig_busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
